pipelined_adder_sub: RTL and testbench

- Parametrised, pipelined successor to the team's fixed 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per pipeline stage; carry passes stage to stage in registers.
- Valid/ready handshake on both sides, full-throughput, stalls cleanly under backpressure.
- Feeds the UART result path, replacing combinational adders where timing fails at wide widths.

---
 rtl/pipelined_adder_sub_if.sv | 35 +++
 rtl/pipelined_adder_sub.sv | 107 ++++++++++
 tb/tb_pipelined_adder_sub.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_sub_if.sv
// Operand/result handshake bundle for pipelined_adder_sub.
// ovf_o exists only when PIPELINED_ADDER_OVF_EN is defined.
interface pipelined_adder_sub_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             sub_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] s_o;
  logic             cout_o;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             ovf_o;
`endif

  modport slave (
    input  valid_i, a_i, b_i, cin_i, sub_i, ready_i,
    output ready_o, valid_o, s_o, cout_o
`ifdef PIPELINED_ADDER_OVF_EN
    , output ovf_o
`endif
  );

  modport master (
    output valid_i, a_i, b_i, cin_i, sub_i, ready_i,
    input  ready_o, valid_o, s_o, cout_o
`ifdef PIPELINED_ADDER_OVF_EN
    , input ovf_o
`endif
  );
endinterface

// File: rtl/pipelined_adder_sub.sv
// Pipelined WIDTH-bit add/subtract, CHUNK bits per stage, global-stall valid/ready.
// Define PIPELINED_ADDER_OVF_EN to add the signed-overflow output ovf_o.
module pipelined_adder_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  pipelined_adder_sub_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("pipelined_adder_sub: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic [STAGES-1:0]            v_q, v_d, c_q, c_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [STAGES-1:0]            src_v, src_c;
  logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_s;
  logic [CHUNK:0]               chunk_sum;
  logic                         pipe_en;
`ifdef PIPELINED_ADDER_OVF_EN
  logic                         ovf_q, ovf_d;
`endif

  always_comb begin
    pipe_en   = ~v_q[LAST] | bus.ready_i;
    chunk_sum = '0;
    src_v     = '0;
    src_c     = '0;
    src_a     = '0;
    src_b     = '0;
    src_s     = '0;
    v_d       = '0;
    c_d       = '0;
    a_d       = '0;
    b_d       = '0;
    s_d       = '0;

    // Stage 0 sources come straight from the port with B and carry already made effective.
    src_v[0] = bus.valid_i;
    src_a[0] = bus.a_i;
    src_b[0] = bus.sub_i ? ~bus.b_i : bus.b_i;
    src_c[0] = bus.sub_i | bus.cin_i;
    src_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
      src_s[k] = s_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      chunk_sum = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, src_c[k]};
      v_d[k] = src_v[k];
      a_d[k] = src_a[k];
      b_d[k] = src_b[k];
      c_d[k] = chunk_sum[CHUNK];
      s_d[k] = src_s[k];
      s_d[k][k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

`ifdef PIPELINED_ADDER_OVF_EN
    // Carry into the MSB recovered from its sum bit, compared with the carry out.
    ovf_d = (src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1]) ^ c_d[LAST];
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
      c_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
`ifdef PIPELINED_ADDER_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (pipe_en) begin
      v_q <= v_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
`ifdef PIPELINED_ADDER_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign bus.ready_o = pipe_en;
  assign bus.valid_o = v_q[LAST];
  assign bus.s_o     = s_q[LAST];
  assign bus.cout_o  = c_q[LAST];
`ifdef PIPELINED_ADDER_OVF_EN
  assign bus.ovf_o   = ovf_q;
`endif

  // Operand chunks already consumed, and the final stage's operand copy, are never read.
  logic unused_bits;
  assign unused_bits = ^{a_q, b_q};
endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Scoreboard bench for pipelined_adder_sub at WIDTH=32, CHUNK=8.
module tb_pipelined_adder_sub;
  localparam int W   = 32;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_sub_if #(.WIDTH(W)) bus ();

  pipelined_adder_sub #(.WIDTH(W), .CHUNK(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [W:0] res;
    logic       ovf;
    int         acc_cyc;
    bit         lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input bit lat);
    exp_t e;
    logic [W-1:0] be;
    int guard;
    bus.valid_i = 1'b1;
    bus.a_i = a;
    bus.b_i = b;
    bus.cin_i = cin;
    bus.sub_i = sub;
    guard = 0;
    forever begin
      @(negedge clk);
      if (bus.ready_o) break;
      guard++;
      if (guard > 100) begin
        chk("send_timeout", {63'b0, bus.ready_o}, 64'd1);
        break;
      end
    end
    be = sub ? ~b : b;
    e.res = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub | cin)};
    e.ovf = (a[W-1] == be[W-1]) && (e.res[W-1] != a[W-1]);
    e.acc_cyc = cyc;
    e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 60) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    bit holding = 0;
    logic [W-1:0] held_s;
    logic held_c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holding = 0;
        continue;
      end
      if (holding) begin
        chk("hold_v", {63'b0, bus.valid_o}, 64'd1);
        chk("hold_s", {32'b0, bus.s_o}, {32'b0, held_s});
        chk("hold_c", {63'b0, bus.cout_o}, {63'b0, held_c});
      end
      holding = 0;
      if (bus.valid_o && !bus.ready_i) begin
        holding = 1;
        held_s = bus.s_o;
        held_c = bus.cout_o;
      end
      if (bus.valid_o && bus.ready_i) begin
        if (sb.size() == 0) begin
          chk("extra_result", {63'b0, bus.valid_o}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("sum", {32'b0, bus.s_o}, {32'b0, e.res[W-1:0]});
          chk("cout", {63'b0, bus.cout_o}, {63'b0, e.res[W]});
`ifdef PIPELINED_ADDER_OVF_EN
          chk("ovf", {63'b0, bus.ovf_o}, {63'b0, e.ovf});
`endif
          if (e.lat) chk("latency", cyc, e.acc_cyc + LAT);
          n_out++;
        end
      end
    end
  end

  initial begin : main
    int base;
    bus.valid_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.cin_i = 1'b0;
    bus.sub_i = 1'b0;
    bus.ready_i = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_o", {63'b0, bus.valid_o}, 64'd0);
    chk("rst_ready_o", {63'b0, bus.ready_o}, 64'd1);
    chk("rst_s_o", {32'b0, bus.s_o}, 64'd0);
    chk("rst_cout_o", {63'b0, bus.cout_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1);
    send(32'd5, 32'd7, 1'b0, 1'b1, 1);
    send(32'd7, 32'd5, 1'b1, 1'b1, 1);
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1);
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1);
    send(32'd3, 32'd4, 1'b0, 1'b0, 1);
    wait_drain();

    // Back-to-back stream with a 3-cycle downstream stall after the second result.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(i, 32'h10, 1'b0, 1'b0, 0);
      end
      begin
        int guard = 0;
        while (n_out < base + 2 && guard < 100) begin
          @(negedge clk);
          guard++;
        end
        if (n_out < base + 2) chk("stall_wait_timeout", n_out, base + 2);
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("stall_ready_o", {63'b0, bus.ready_o}, 64'd0);
          @(posedge clk);
          #1;
        end
        bus.ready_i = 1'b1;
      end
    join
    wait_drain();
    chk("stream_count", n_out, base + 8);

    // Reset with three operations in flight, the oldest parked at the output.
    send(32'd100, 32'd1, 1'b0, 1'b0, 0);
    send(32'd200, 32'd2, 1'b0, 1'b0, 0);
    send(32'd300, 32'd3, 1'b0, 1'b0, 0);
    bus.ready_i = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_valid", {63'b0, bus.valid_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_o", {63'b0, bus.valid_o}, 64'd0);
    chk("mid_rst_ready_o", {63'b0, bus.ready_o}, 64'd1);
    chk("mid_rst_s_o", {32'b0, bus.s_o}, 64'd0);
    sb.delete();
    bus.ready_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send(32'd1, 32'd1, 1'b0, 1'b0, 1);
    wait_drain();
    chk("final_queue", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
